// File: rtl/id_ex_hazard_stage.sv
// id_ex_hazard_stage: ID/EX pipeline register with load-use stall, flush bubbles and forwarding selects
module id_ex_hazard_stage #(
  parameter int DW = 32,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic [4:0]    id_rd,
  input  logic          id_uses_rt,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic [CW-1:0] id_ctrl,
  input  logic          flush,
  input  logic          exmem_reg_write,
  input  logic [4:0]    exmem_rd,
  input  logic          memwb_reg_write,
  input  logic [4:0]    memwb_rd,
  output logic          ex_valid,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic [CW-1:0] ex_ctrl,
  output logic [DW-1:0] ex_rs_data,
  output logic [DW-1:0] ex_rt_data,
  output logic [DW-1:0] ex_imm,
  output logic [4:0]    ex_rs,
  output logic [4:0]    ex_rt,
  output logic [4:0]    ex_rd,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          stall,
  output logic [15:0]   stall_count
);
  logic bubble;
  // load-use hazard on a load in EX; a flush kills the ID instruction so it never stalls
  always_comb begin
    stall  = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
             ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt))) & ~flush;
    bubble = stall | flush;
  end
  // operand forwarding selects; the younger EX/MEM result wins over MEM/WB
  always_comb begin
    fwd_a = (ex_valid & exmem_reg_write & (exmem_rd != 5'd0) & (exmem_rd == ex_rs)) ? 2'd2 :
            (ex_valid & memwb_reg_write & (memwb_rd != 5'd0) & (memwb_rd == ex_rs)) ? 2'd1 : 2'd0;
    fwd_b = (ex_valid & exmem_reg_write & (exmem_rd != 5'd0) & (exmem_rd == ex_rt)) ? 2'd2 :
            (ex_valid & memwb_reg_write & (memwb_rd != 5'd0) & (memwb_rd == ex_rt)) ? 2'd1 : 2'd0;
  end
  // ID/EX register: take the ID instruction, or an all-zero bubble on stall or flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst || bubble) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_ctrl      <= '0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      ex_imm       <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_rd        <= '0;
    end else begin
      ex_valid     <= id_valid;
      ex_reg_write <= id_reg_write;
      ex_mem_read  <= id_mem_read;
      ex_mem_write <= id_mem_write;
      ex_ctrl      <= id_ctrl;
      ex_rs_data   <= id_rs_data;
      ex_rt_data   <= id_rt_data;
      ex_imm       <= id_imm;
      ex_rs        <= id_rs;
      ex_rt        <= id_rt;
      ex_rd        <= id_rd;
    end
  end
  // saturating count of load-use stall cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_count <= '0;
    else if (stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
  end
endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// tb_id_ex_hazard_stage: randomized and directed checks of the ID/EX hazard stage against a behavioural model
module tb_id_ex_hazard_stage;
  localparam int DW = 32;
  localparam int CW = 8;
  typedef struct packed {
    logic v, rw, mr, mw;
    logic [CW-1:0] c;
    logic [DW-1:0] a, b, i;
    logic [4:0] rs, rt, rd;
  } ex_t;
  logic clk = 0, rst = 1;
  logic id_valid = 0, id_uses_rt = 0, id_reg_write = 0, id_mem_read = 0, id_mem_write = 0, flush = 0;
  logic [DW-1:0] id_rs_data = 0, id_rt_data = 0, id_imm = 0;
  logic [4:0] id_rs = 0, id_rt = 0, id_rd = 0, exmem_rd = 0, memwb_rd = 0;
  logic [CW-1:0] id_ctrl = 0;
  logic exmem_reg_write = 0, memwb_reg_write = 0;
  logic ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, stall;
  logic [CW-1:0] ex_ctrl;
  logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0] ex_rs, ex_rt, ex_rd;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_count;
  int checks = 0, errors = 0;
  ex_t m = '0;
  int n = 0;
  int base = 0;

  id_ex_hazard_stage #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_ctrl(id_ctrl), .flush(flush), .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_ctrl(ex_ctrl), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall(stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic m_stall();
    if (!(m.v && m.mr && m.rd != 0 && id_valid) || flush) return 1'b0;
    return (m.rd == id_rs) || (id_uses_rt && m.rd == id_rt);
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (!m.v || src == 0) return 2'd0;
    if (exmem_reg_write && exmem_rd == src) return 2'd2;
    if (memwb_reg_write && memwb_rd == src) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [15:0] m_count();
    return (base + n > 65535) ? 16'hFFFF : 16'(base + n);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m <= '0;
      n <= 0;
    end else begin
      m <= (flush || m_stall()) ? '0 :
           ex_t'{id_valid, id_reg_write, id_mem_read, id_mem_write, id_ctrl,
                 id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd};
      n <= n + int'(m_stall());
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("ex_fields", {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_ctrl,
                      ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd}, m);
    chk("stall", stall, m_stall());
    chk("fwd_a", fwd_a, m_fwd(m.rs));
    chk("fwd_b", fwd_b, m_fwd(m.rt));
    chk("stall_count", stall_count, m_count());
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic ut, input logic mr);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = ut;
    id_mem_read = mr; id_reg_write = v; id_mem_write = 0;
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom; id_ctrl = 8'($urandom);
  endtask

  task automatic do_reset();
    rst = 1; base = 0;
    step();
    rst = 0;
  endtask

  initial begin
    step();
    chk("reset_valid", ex_valid, 1'b0);
    chk("reset_count", stall_count, 16'd0);
    rst = 0;
    // lw $2 then dependent add
    set_id(1, 5'd1, 5'd0, 5'd2, 0, 1);
    step();
    set_id(1, 5'd2, 5'd3, 5'd4, 1, 0);
    #1 chk("load_use_stall", stall, 1'b1);
    step();
    chk("bubble_valid", ex_valid, 1'b0);
    chk("bubble_count", stall_count, 16'd1);
    chk("bubble_stall_drop", stall, 1'b0);
    step();
    chk("add_loaded", {ex_valid, ex_rd, ex_rs}, {1'b1, 5'd4, 5'd2});
    // forwarding priority on rs=5
    set_id(1, 5'd5, 5'd6, 5'd7, 1, 0);
    step();
    exmem_rd = 5; exmem_reg_write = 1; memwb_rd = 5; memwb_reg_write = 1;
    #1 chk("fwd_a_exmem", fwd_a, 2'd2);
    exmem_reg_write = 0;
    #1 chk("fwd_a_memwb", fwd_a, 2'd1);
    // register 0 never forwarded
    set_id(1, 5'd1, 5'd0, 5'd8, 1, 0);
    step();
    exmem_rd = 0; exmem_reg_write = 1; memwb_rd = 0; memwb_reg_write = 1;
    #1 chk("fwd_b_zero", fwd_b, 2'd0);
    exmem_reg_write = 0; memwb_reg_write = 0;
    // load-use together with flush
    set_id(1, 5'd1, 5'd0, 5'd7, 0, 1);
    step();
    set_id(1, 5'd7, 5'd0, 5'd9, 0, 0);
    flush = 1;
    #1 chk("flush_no_stall", stall, 1'b0);
    step();
    flush = 0;
    chk("flush_bubble", ex_valid, 1'b0);
    chk("flush_count", stall_count, 16'd1);
    // reset asserted mid-stall
    set_id(1, 5'd1, 5'd0, 5'd3, 0, 1);
    step();
    set_id(1, 5'd3, 5'd0, 5'd4, 0, 0);
    #1 chk("pre_rst_stall", stall, 1'b1);
    rst = 1; base = 0;
    #1 chk("rst_drops_stall", {stall, ex_valid, ex_mem_read}, 3'b000);
    step();
    rst = 0;
    // asynchronous reset between edges with a valid instruction in EX
    set_id(1, 5'd5, 5'd6, 5'd7, 1, 0);
    exmem_rd = 5; exmem_reg_write = 1;
    step();
    chk("pre_rst_valid", {ex_valid, fwd_a}, {1'b1, 2'd2});
    #1 rst = 1; base = 0;
    #1 chk("async_rst_fields", {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_ctrl,
                                ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd}, 128'd0);
    chk("async_rst_ctl", {fwd_a, fwd_b, stall, stall_count}, 21'd0);
    step();
    rst = 0; exmem_reg_write = 0;
    // saturation from a preset near the top
    set_id(1, 5'd1, 5'd0, 5'd2, 0, 1);
    step();
    set_id(1, 5'd2, 5'd0, 5'd2, 0, 1);
    force dut.stall_count = 16'hFFFE;
    base = 65534 - n;
    #1 release dut.stall_count;
    step();
    chk("sat_reach", stall_count, 16'hFFFF);
    step();
    #1 chk("sat_stall_again", stall, 1'b1);
    step();
    chk("sat_hold", stall_count, 16'hFFFF);
    do_reset();
    // randomized traffic over a small register window to provoke hazards
    for (int k = 0; k < 3000; k++) begin
      set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
      id_mem_write = 1'($urandom);
      flush = $urandom_range(0, 7) == 0;
      exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3));
      memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3));
      step();
    end
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
